// File: rtl/adxl345_i2c_responder_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// adxl345_i2c_responder_if : open-drain I2C bus seen by the ADXL345 responder
// Revision 1.0
// ----------------------------------------------------------------------------
interface adxl345_i2c_responder_if;
  logic Scl;
  logic Sda;
  logic Sda_oe;

  modport slave  (input Scl, input Sda, output Sda_oe);
  modport master (output Scl, output Sda, input Sda_oe);
endinterface
`default_nettype wire

// File: rtl/adxl345_i2c_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// adxl345_i2c_responder : oversampled I2C target emulating the ADXL345 registers
// Revision 1.0
// ----------------------------------------------------------------------------
module adxl345_i2c_responder #(
  parameter logic [6:0] slave_address_p = 7'h53,
  parameter logic [7:0] devid_p         = 8'hE5,
  parameter int         sync_stages_p   = 2
) (
  input  logic                          Clk_i,
  input  logic                          Reset_i,
  adxl345_i2c_responder_if.slave        bus_if,
  input  logic [15:0]                   X_i,
  input  logic [15:0]                   Y_i,
  input  logic [15:0]                   Z_i,
  output logic [7:0]                    Bw_Rate_o,
  output logic [7:0]                    Power_Ctl_o,
  output logic [7:0]                    Data_Format_o,
  output logic                          Reg_Wr_Strobe_o,
  output logic                          Busy_o
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    ADDR_ACK  = 4'd2,
    PTR       = 4'd3,
    PTR_ACK   = 4'd4,
    WR_DATA   = 4'd5,
    WR_ACK    = 4'd6,
    RD_DATA   = 4'd7,
    RD_ACK    = 4'd8,
    WAIT_STOP = 4'd9
  } state_t;

  logic [sync_stages_p-1:0] scl_sync_q, sda_sync_q;
  logic                     scl_hist_q, sda_hist_q;
  logic                     scl_s, sda_s;
  logic                     scl_rise, scl_fall, start_det, stop_det;

  state_t      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  rx_q, rx_d;
  logic [6:0]  tx_q, tx_d;
  logic [7:0]  ptr_q, ptr_d;
  logic        oe_q, oe_d;
  logic        busy_q, busy_d;
  logic        strobe_q, strobe_d;
  logic [7:0]  bw_q, bw_d, pwr_q, pwr_d, fmt_q, fmt_d;
  logic [15:0] x_sh_q, x_sh_d, y_sh_q, y_sh_d, z_sh_q, z_sh_d;
  logic [7:0]  rd_byte;

  assign scl_s     = scl_sync_q[sync_stages_p-1];
  assign sda_s     = sda_sync_q[sync_stages_p-1];
  assign scl_rise  =  scl_s & ~scl_hist_q;
  assign scl_fall  = ~scl_s &  scl_hist_q;
  assign start_det =  scl_s &  scl_hist_q &  sda_hist_q & ~sda_s;
  assign stop_det  =  scl_s &  scl_hist_q & ~sda_hist_q &  sda_s;

  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[sync_stages_p-2:0], bus_if.Scl};
      sda_sync_q <= {sda_sync_q[sync_stages_p-2:0], bus_if.Sda};
      scl_hist_q <= scl_s;
      sda_hist_q <= sda_s;
    end
  end

  always_comb begin
    rd_byte = 8'h00;
    case (ptr_q)
      8'h00:   rd_byte = devid_p;
      8'h2C:   rd_byte = bw_q;
      8'h2D:   rd_byte = pwr_q;
      8'h31:   rd_byte = fmt_q;
      8'h32:   rd_byte = x_sh_q[7:0];
      8'h33:   rd_byte = x_sh_q[15:8];
      8'h34:   rd_byte = y_sh_q[7:0];
      8'h35:   rd_byte = y_sh_q[15:8];
      8'h36:   rd_byte = z_sh_q[7:0];
      8'h37:   rd_byte = z_sh_q[15:8];
      default: rd_byte = 8'h00;
    endcase
  end

  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      state_q   <= IDLE;
      bit_cnt_q <= 4'd0;
      rx_q      <= 8'h00;
      tx_q      <= 7'h00;
      ptr_q     <= 8'h00;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      strobe_q  <= 1'b0;
      bw_q      <= 8'h0A;
      pwr_q     <= 8'h00;
      fmt_q     <= 8'h00;
      x_sh_q    <= 16'h0000;
      y_sh_q    <= 16'h0000;
      z_sh_q    <= 16'h0000;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      ptr_q     <= ptr_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
      strobe_q  <= strobe_d;
      bw_q      <= bw_d;
      pwr_q     <= pwr_d;
      fmt_q     <= fmt_d;
      x_sh_q    <= x_sh_d;
      y_sh_q    <= y_sh_d;
      z_sh_q    <= z_sh_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    ptr_d     = ptr_q;
    oe_d      = oe_q;
    busy_d    = busy_q;
    strobe_d  = 1'b0;
    bw_d      = bw_q;
    pwr_d     = pwr_q;
    fmt_d     = fmt_q;
    x_sh_d    = x_sh_q;
    y_sh_d    = y_sh_q;
    z_sh_d    = z_sh_q;

    // Bus conditions override whatever byte phase is in progress.
    if (stop_det) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = 4'd0;
      oe_d      = 1'b0;
    end else begin
      case (state_q)
        ADDR, PTR, WR_DATA: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            rx_d      = {rx_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_d = 4'd0;
            if (state_q == ADDR) begin
              if (rx_q[7:1] == slave_address_p) begin
                oe_d    = 1'b1;
                busy_d  = 1'b1;
                state_d = ADDR_ACK;
                if (rx_q[0]) begin
                  x_sh_d = X_i;
                  y_sh_d = Y_i;
                  z_sh_d = Z_i;
                end
              end else begin
                state_d = WAIT_STOP;
              end
            end else if (state_q == PTR) begin
              ptr_d   = rx_q;
              oe_d    = 1'b1;
              state_d = PTR_ACK;
            end else begin
              oe_d    = 1'b1;
              state_d = WR_ACK;
              ptr_d   = ptr_q + 8'd1;
              case (ptr_q)
                8'h2C: begin bw_d  = rx_q; strobe_d = 1'b1; end
                8'h2D: begin pwr_d = rx_q; strobe_d = 1'b1; end
                8'h31: begin fmt_d = rx_q; strobe_d = 1'b1; end
                default: ;
              endcase
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (rx_q[0]) begin
              tx_d    = rd_byte[6:0];
              oe_d    = ~rd_byte[7];
              state_d = RD_DATA;
            end else begin
              oe_d    = 1'b0;
              state_d = PTR;
            end
          end
        end
        PTR_ACK, WR_ACK: begin
          if (scl_fall) begin
            oe_d    = 1'b0;
            state_d = WR_DATA;
          end
        end
        RD_DATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              bit_cnt_d = 4'd0;
              oe_d      = 1'b0;
              state_d   = RD_ACK;
            end else begin
              oe_d = ~tx_q[6];
              tx_d = {tx_q[5:0], 1'b0};
            end
          end
        end
        RD_ACK: begin
          // Pointer advances on the master's ACK so the next byte is fetched on the fall.
          if (scl_rise) begin
            if (sda_s) state_d = WAIT_STOP;
            else       ptr_d   = ptr_q + 8'd1;
          end else if (scl_fall) begin
            tx_d    = rd_byte[6:0];
            oe_d    = ~rd_byte[7];
            state_d = RD_DATA;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus_if.Sda_oe   = oe_q;
  assign Busy_o          = busy_q;
  assign Reg_Wr_Strobe_o = strobe_q;
  assign Bw_Rate_o       = bw_q;
  assign Power_Ctl_o     = pwr_q;
  assign Data_Format_o   = fmt_q;

endmodule
`default_nettype wire

// File: tb/tb_adxl345_i2c_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_adxl345_i2c_responder : directed I2C master with read-data scoreboard
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_adxl345_i2c_responder;
  localparam int Q = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_scl, m_sda;
  logic [15:0] x_v, y_v, z_v;
  logic [7:0]  bw, pwr, fmt;
  logic        strobe, busy;
  int          checks = 0;
  int          failures = 0;
  int          strobe_cnt = 0;
  int          oe_cnt = 0;
  logic [7:0]  exp_q[$];

  adxl345_i2c_responder_if bus_if ();
  assign bus_if.Scl = m_scl;
  assign bus_if.Sda = m_sda & ~bus_if.Sda_oe;

  adxl345_i2c_responder #(
    .slave_address_p(7'h53),
    .devid_p        (8'hE5),
    .sync_stages_p  (2)
  ) dut (
    .Clk_i          (clk),
    .Reset_i        (rst),
    .bus_if         (bus_if.slave),
    .X_i            (x_v),
    .Y_i            (y_v),
    .Z_i            (z_v),
    .Bw_Rate_o      (bw),
    .Power_Ctl_o    (pwr),
    .Data_Format_o  (fmt),
    .Reg_Wr_Strobe_o(strobe),
    .Busy_o         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (strobe)        strobe_cnt <= strobe_cnt + 1;
    if (bus_if.Sda_oe) oe_cnt     <= oe_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wait_clks(Q);
    m_scl = 1'b1; wait_clks(Q);
    m_sda = 1'b0; wait_clks(Q);
    m_scl = 1'b0; wait_clks(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wait_clks(Q);
    m_scl = 1'b1; wait_clks(Q);
    m_sda = 1'b1; wait_clks(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      m_sda = b[i]; wait_clks(Q);
      m_scl = 1'b1; wait_clks(2 * Q);
      m_scl = 1'b0; wait_clks(Q);
    end
    m_sda = 1'b1; wait_clks(Q);
    m_scl = 1'b1; wait_clks(Q);
    ack = bus_if.Sda;
    wait_clks(Q);
    m_scl = 1'b0; wait_clks(Q);
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] d);
    m_sda = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      wait_clks(Q);
      m_scl = 1'b1; wait_clks(Q);
      d[i] = bus_if.Sda;
      wait_clks(Q);
      m_scl = 1'b0;
    end
    wait_clks(Q);
    m_sda = master_ack ? 1'b0 : 1'b1; wait_clks(Q);
    m_scl = 1'b1; wait_clks(2 * Q);
    m_scl = 1'b0; wait_clks(Q);
    m_sda = 1'b1;
  endtask

  task automatic read_and_score(input string tag, input logic master_ack);
    logic [7:0] d;
    logic [7:0] e;
    read_byte(master_ack, d);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    check(tag, {8'h00, d}, {8'h00, e});
  endtask

  task automatic send_checked(input string tag, input logic [7:0] b, input logic exp_ack);
    logic a;
    write_byte(b, a);
    check(tag, {15'h0, a}, {15'h0, exp_ack});
  endtask

  initial begin
    int s0;
    int o0;
    m_scl = 1'b1; m_sda = 1'b1;
    x_v = '0; y_v = '0; z_v = '0;
    rst = 1'b1;
    wait_clks(5);
    check("rst_oe",     {15'h0, bus_if.Sda_oe}, 16'h0);
    check("rst_busy",   {15'h0, busy},          16'h0);
    check("rst_strobe", {15'h0, strobe},        16'h0);
    check("rst_bw",     {8'h0, bw},             16'h0A);
    check("rst_pwr",    {8'h0, pwr},            16'h00);
    check("rst_fmt",    {8'h0, fmt},            16'h00);
    rst = 1'b0;
    wait_clks(5);

    // DEVID read through a repeated START
    i2c_start();
    send_checked("devid_addr_w_ack", 8'hA6, 1'b0);
    send_checked("devid_ptr_ack",    8'h00, 1'b0);
    i2c_start();
    send_checked("devid_addr_r_ack", 8'hA7, 1'b0);
    exp_q.push_back(8'hE5);
    read_and_score("devid_byte", 1'b0);
    check("devid_busy_before_stop", {15'h0, busy}, 16'h1);
    i2c_stop();
    wait_clks(Q);
    check("devid_busy_after_stop", {15'h0, busy}, 16'h0);

    // Register write to POWER_CTL
    i2c_start();
    send_checked("wr_addr_ack", 8'hA6, 1'b0);
    send_checked("wr_ptr_ack",  8'h2D, 1'b0);
    s0 = strobe_cnt;
    send_checked("wr_data_ack", 8'h08, 1'b0);
    i2c_stop();
    wait_clks(Q);
    check("wr_pwr",        {8'h0, pwr}, 16'h08);
    check("wr_strobe_cnt", 16'(strobe_cnt - s0), 16'd1);

    // Write to an unmapped register
    i2c_start();
    send_checked("wr10_addr_ack", 8'hA6, 1'b0);
    send_checked("wr10_ptr_ack",  8'h10, 1'b0);
    s0 = strobe_cnt;
    send_checked("wr10_data_ack", 8'h55, 1'b0);
    i2c_stop();
    wait_clks(Q);
    check("wr10_strobe_cnt", 16'(strobe_cnt - s0), 16'd0);
    check("wr10_pwr", {8'h0, pwr}, 16'h08);
    check("wr10_bw",  {8'h0, bw},  16'h0A);
    check("wr10_fmt", {8'h0, fmt}, 16'h00);

    // Coherent 6-byte axis burst
    x_v = 16'h0123; y_v = 16'hFF80; z_v = 16'h7FFF;
    exp_q.push_back(x_v[7:0]); exp_q.push_back(x_v[15:8]);
    exp_q.push_back(y_v[7:0]); exp_q.push_back(y_v[15:8]);
    exp_q.push_back(z_v[7:0]); exp_q.push_back(z_v[15:8]);
    i2c_start();
    send_checked("xyz_addr_w_ack", 8'hA6, 1'b0);
    send_checked("xyz_ptr_ack",    8'h32, 1'b0);
    i2c_start();
    send_checked("xyz_addr_r_ack", 8'hA7, 1'b0);
    read_and_score("xyz_b0", 1'b1);
    x_v = 16'h0000;
    read_and_score("xyz_b1", 1'b1);
    read_and_score("xyz_b2", 1'b1);
    read_and_score("xyz_b3", 1'b1);
    read_and_score("xyz_b4", 1'b1);
    read_and_score("xyz_b5", 1'b0);
    i2c_stop();
    wait_clks(Q);

    // Foreign address: never drive SDA, ignore the rest of the transfer
    o0 = oe_cnt;
    i2c_start();
    send_checked("nomatch_nack", 8'h3A, 1'b1);
    send_checked("nomatch_ptr",  8'h31, 1'b1);
    send_checked("nomatch_data", 8'h99, 1'b1);
    check("nomatch_oe_cycles", 16'(oe_cnt - o0), 16'd0);
    check("nomatch_busy", {15'h0, busy}, 16'h0);
    i2c_stop();
    wait_clks(Q);
    check("nomatch_fmt", {8'h0, fmt}, 16'h00);

    // Pointer wrap 0xFF -> 0x00
    exp_q.push_back(8'h00); exp_q.push_back(8'hE5);
    i2c_start();
    send_checked("wrap_addr_w_ack", 8'hA6, 1'b0);
    send_checked("wrap_ptr_ack",    8'hFF, 1'b0);
    i2c_start();
    send_checked("wrap_addr_r_ack", 8'hA7, 1'b0);
    read_and_score("wrap_b0", 1'b1);
    read_and_score("wrap_b1", 1'b0);
    i2c_stop();
    wait_clks(Q);

    // Reset in the middle of a read byte (reading POWER_CTL=0x08, bit 4 driven low)
    i2c_start();
    send_checked("rstmid_addr_w_ack", 8'hA6, 1'b0);
    send_checked("rstmid_ptr_ack",    8'h2C, 1'b0);
    send_checked("rstmid_data_ack",   8'h0F, 1'b0);
    i2c_stop();
    wait_clks(Q);
    check("rstmid_bw_written", {8'h0, bw}, 16'h0F);
    i2c_start();
    send_checked("rstmid_addr_r_ack", 8'hA7, 1'b0);
    m_sda = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_clks(Q);
      m_scl = 1'b1; wait_clks(2 * Q);
      m_scl = 1'b0;
    end
    wait_clks(Q);
    check("rstmid_bit4_driven", {15'h0, bus_if.Sda_oe}, 16'h1);
    m_scl = 1'b1; wait_clks(Q);
    rst = 1'b1;
    wait_clks(1);
    check("rstmid_oe_released", {15'h0, bus_if.Sda_oe}, 16'h0);
    wait_clks(3);
    check("rstmid_bw",   {8'h0, bw},    16'h0A);
    check("rstmid_pwr",  {8'h0, pwr},   16'h00);
    check("rstmid_busy", {15'h0, busy}, 16'h0);
    rst = 1'b0;
    wait_clks(Q);

    // Pointer is back at 0x00, so a plain read returns DEVID
    exp_q.push_back(8'hE5);
    i2c_start();
    send_checked("post_rst_addr_r_ack", 8'hA7, 1'b0);
    read_and_score("post_rst_devid", 1'b0);
    i2c_stop();
    wait_clks(Q);
    check("scoreboard_empty", 16'(exp_q.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/adxl345_i2c_responder.md
Name: adxl345_i2c_responder

Overview:
- Synthesizable I2C target that emulates the ADXL345 register interface, answering the existing I2C single-read and burst-read masters.
- Replaces the behavioural SDA stimulus in the board-level bench, and lets the master be loop-tested on the FPGA without a sensor.
- Oversamples SCL/SDA on the system clock, decodes START/STOP, address, register pointer, writes and auto-incrementing reads.
- Axis values come from ports and are snapshotted per read transaction so that multi-byte reads are coherent.

Parameters:
slave_address_p, 7'h53, 7-bit I2C address matched (ADXL345 ALT ADDRESS low)
devid_p, 8'hE5, value returned for register 0x00
sync_stages_p, 2, synchroniser depth on Scl_i/Sda_i (allowed range 2..4)

Ports:
Clk_i  in  1  system clock
Reset_i  in  1  reset; synchronous, active-high
Scl_i  in  1  I2C clock from the bus (asynchronous)
Sda_i  in  1  I2C data read back from the bus (asynchronous)
Sda_oe_o  out  1  1 = pull SDA low; 0 = release (open-drain, tristate in the top level)
X_i  in  16  signed X sample, two's complement
Y_i  in  16  signed Y sample
Z_i  in  16  signed Z sample
Bw_Rate_o  out  8  register 0x2C contents
Power_Ctl_o  out  8  register 0x2D contents
Data_Format_o  out  8  register 0x31 contents
Reg_Wr_Strobe_o  out  1  one-cycle pulse after each accepted register write
Busy_o  out  1  1 from an address match until STOP

Behaviour:
- Reset (Reset_i=1 sampled on a Clk_i rising edge) applies the following values:
  - Sda_oe_o=0, Busy_o=0, Reg_Wr_Strobe_o=0.
  - Bw_Rate_o=8'h0A, Power_Ctl_o=8'h00, Data_Format_o=8'h00.
  - Pointer=8'h00, FSM=IDLE, synchroniser flops=1.
- Edge detection runs on synchronised signals (sync_stages_p flops plus one history flop).
  - scl_rise/scl_fall are one-cycle pulses.
  - START = SDA falling while SCL high. STOP = SDA rising while SCL high.
  - Total latency from bus edge to FSM action is at most sync_stages_p+1 cycles.
- Timing rules:
  - SDA is sampled on scl_rise.
  - Sda_oe_o changes only on scl_fall, or on STOP/reset.
  - A START is recognised in every state, including repeated START mid-read: bit counter cleared, Sda_oe_o=0, go to ADDR.
  - A STOP is recognised in every state: go to IDLE, Sda_oe_o=0, Busy_o=0.
- FSM states:
  - IDLE: wait for START.
  - ADDR: shift in 8 bits, MSB first.
    - Bits [7:1] equal slave_address_p: on scl_fall after the 8th bit assert Sda_oe_o=1, go to ADDR_ACK, Busy_o=1.
    - No match: go to WAIT_STOP, SDA never driven.
    - Match with R/W=1: capture X_i/Y_i/Z_i into shadow registers in the same cycle as the ACK assertion.
  - ADDR_ACK: on the next scl_fall, R/W=0 -> release SDA, go to PTR. R/W=1 -> drive bit7 of the read byte, go to RD_DATA.
  - PTR: shift in 8 bits into the pointer, then ACK (PTR_ACK), then go to WR_DATA.
  - WR_DATA: shift in 8 bits, then ACK (WR_ACK).
    - In the ACK-assert cycle, write the byte if the pointer is 0x2C, 0x2D or 0x31, and pulse Reg_Wr_Strobe_o.
    - Writes to any other address are ACKed and discarded, with no strobe.
    - Pointer increments. Further bytes loop back to WR_DATA.
  - RD_DATA: drive 8 bits MSB first; Sda_oe_o = ~bit. After the 8th bit's scl_fall, release SDA and go to RD_ACK.
  - RD_ACK: sample the master bit on scl_rise.
    - 0 (ACK): pointer increments; on the next scl_fall drive bit7 of the next byte.
    - 1 (NACK): go to WAIT_STOP.
  - WAIT_STOP: SDA released; leave only on START or STOP.
- Read map (all other addresses read 8'h00):
  - 0x00 = devid_p
  - 0x2C, 0x2D, 0x31 = their registers
  - 0x32..0x37 = shadow X[7:0], X[15:8], Y[7:0], Y[15:8], Z[7:0], Z[15:8]
- The pointer is 8 bits and wraps 0xFF -> 0x00. The pointer persists across transactions, so a repeated START read continues from the last written pointer.
- Reset asserted mid-transfer: immediate return to the reset values above; SDA is released in the same cycle.

Test Plan:
- Write 0xA6 (address 0x53, W), 0x00, repeated START, 0xA7, read 1 byte, NACK, STOP -> byte = 0xE5; ACK driven on the three ACK slots; Busy_o falls after STOP.
- Write 0xA6, 0x2D, 0x08, STOP -> Power_Ctl_o=8'h08 and one Reg_Wr_Strobe_o pulse. Same with pointer 0x10 -> ACKed, no strobe, registers unchanged.
- X_i=16'h0123, Y_i=16'hFF80, Z_i=16'h7FFF; pointer 0x32; read 6 bytes, master ACKs 5 and NACKs the last:
  - bytes returned: 23 01 80 FF FF 7F
  - X_i changed to 16'h0000 after byte 1 -> remaining bytes unchanged (shadow holds).
- Address 0x1D (mismatch) -> Sda_oe_o stays 0 through all 9 clocks; FSM ignores traffic until STOP/START.
- Pointer 0xFF, read 2 bytes -> 0x00 (reg 0xFF), then 0xE5 (wrapped to 0x00).
- Reset_i=1 during the 4th bit of a read byte -> Sda_oe_o=0 the next cycle, registers reset (Bw_Rate_o=0x0A); a subsequent full DEVID read succeeds.
